axil_ctrl_slave: RTL and testbench

AXI-Lite slave (responder) terminating the host-side control channel driven by the PCIe/QDMA AXI-Lite master. It holds the card's control/status register bank: version, control word, scratch, sampled status, event counter and a 64-bit free-running cycle counter. It sits between the host AXI-Lite crossbar port and the user-logic control/status nets.

---
 rtl/axil_ctrl_slave_if.sv | 34 +++
 rtl/axil_ctrl_slave.sv | 168 ++++++++++++++++
 tb/tb_axil_ctrl_slave.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_ctrl_slave_if.sv
// AXI-Lite control-channel bundle between the host crossbar port (master)
// and the card register bank (slave).
//   AW: awaddr/awvalid/awready    W: wdata/wstrb/wvalid/wready
//   B : bresp/bvalid/bready       AR: araddr/arvalid/arready
//   R : rdata/rresp/rvalid/rready
interface axil_ctrl_slave_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_ctrl_slave.sv
// AXI-Lite slave holding the card control/status register bank:
// VERSION, CTRL, SCRATCH, STATUS, EVENT_CNT and a 64-bit cycle counter
// read as CYCLE_LO / CYCLE_HI (HI returns the half latched by the LO read).
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   s_axil       - AXI-Lite slave bus (one outstanding write, one outstanding read)
//   ctrl_out     - CTRL register contents
//   status_in    - user status, sampled when STATUS is read
//   event_pulse  - one-cycle event strobe counted in EVENT_CNT
module axil_ctrl_slave #(
  parameter int unsigned ADDR_BITS  = 8,
  parameter logic [31:0] VERSION    = 32'd20200610,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rstn,
  axil_ctrl_slave_if.slave s_axil,
  output logic [31:0]      ctrl_out,
  input  logic [31:0]      status_in,
  input  logic             event_pulse
);

  localparam int unsigned WW = ADDR_BITS - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [WW-1:0] OFF_VERSION   = WW'(0);
  localparam logic [WW-1:0] OFF_CTRL      = WW'(1);
  localparam logic [WW-1:0] OFF_SCRATCH   = WW'(2);
  localparam logic [WW-1:0] OFF_STATUS    = WW'(3);
  localparam logic [WW-1:0] OFF_EVENT_CNT = WW'(4);
  localparam logic [WW-1:0] OFF_CYCLE_LO  = WW'(5);
  localparam logic [WW-1:0] OFF_CYCLE_HI  = WW'(6);

  logic        r_awready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_arready;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic [31:0] r_ctrl;
  logic [31:0] r_scratch;
  logic [31:0] r_evt_cnt;
  logic [31:0] r_shadow;
  logic [63:0] r_cycle;

  logic [WW-1:0] w_wr_word;
  logic [WW-1:0] w_rd_word;
  logic          w_wr_fire;
  logic          w_rd_fire;
  logic          w_wr_hit;
  logic          w_rd_hit;
  logic          w_evt_clr;
  logic [31:0]   w_rd_data;
  logic          w_unused;

  // Only the word offset within the decoded window matters.
  assign w_wr_word = s_axil.awaddr[ADDR_BITS-1:2];
  assign w_rd_word = s_axil.araddr[ADDR_BITS-1:2];
  assign w_unused  = ^{s_axil.awaddr[31:ADDR_BITS], s_axil.awaddr[1:0],
                       s_axil.araddr[31:ADDR_BITS], s_axil.araddr[1:0]};

  // Ready is registered, so the transfer completes on the edge after ready rises.
  assign w_wr_fire = r_awready & s_axil.awvalid & s_axil.wvalid;
  assign w_rd_fire = r_arready & s_axil.arvalid;
  assign w_wr_hit  = (w_wr_word <= OFF_CYCLE_HI);
  assign w_evt_clr = w_wr_fire & (w_wr_word == OFF_EVENT_CNT);

  assign s_axil.awready = r_awready;
  assign s_axil.wready  = r_awready;
  assign s_axil.bvalid  = r_bvalid;
  assign s_axil.bresp   = r_bresp;
  assign s_axil.arready = r_arready;
  assign s_axil.rvalid  = r_rvalid;
  assign s_axil.rresp   = r_rresp;
  assign s_axil.rdata   = r_rdata;
  assign ctrl_out       = r_ctrl;

  // Byte-lane merge for strobed writes.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
    end
    return v;
  endfunction

  // Read data mux; unmapped offsets return zero with an error flag.
  always_comb begin
    w_rd_data = '0;
    w_rd_hit  = 1'b1;
    case (w_rd_word)
      OFF_VERSION:   w_rd_data = VERSION;
      OFF_CTRL:      w_rd_data = r_ctrl;
      OFF_SCRATCH:   w_rd_data = r_scratch;
      OFF_STATUS:    w_rd_data = status_in;
      OFF_EVENT_CNT: w_rd_data = r_evt_cnt;
      OFF_CYCLE_LO:  w_rd_data = r_cycle[31:0];
      OFF_CYCLE_HI:  w_rd_data = r_shadow;
      default:       w_rd_hit  = 1'b0;
    endcase
  end

  // Write channel handshake; AW and W are only taken together, one at a time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_awready <= s_axil.awvalid & s_axil.wvalid & ~r_bvalid & ~r_awready;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && s_axil.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read channel handshake; data and the CYCLE_HI shadow latch on the accept edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_shadow  <= '0;
    end else begin
      r_arready <= s_axil.arvalid & ~r_rvalid & ~r_arready;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
        if (w_rd_word == OFF_CYCLE_LO) r_shadow <= r_cycle[63:32];
      end else if (r_rvalid && s_axil.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Writable registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ctrl    <= CTRL_RESET;
      r_scratch <= '0;
    end else if (w_wr_fire) begin
      if (w_wr_word == OFF_CTRL)    r_ctrl    <= f_merge(r_ctrl, s_axil.wdata, s_axil.wstrb);
      if (w_wr_word == OFF_SCRATCH) r_scratch <= f_merge(r_scratch, s_axil.wdata, s_axil.wstrb);
    end
  end

  // Counters; a clear coincident with a pulse leaves the count at one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_evt_cnt <= '0;
      r_cycle   <= '0;
    end else begin
      r_evt_cnt <= (w_evt_clr ? 32'd0 : r_evt_cnt) + 32'(event_pulse);
      r_cycle   <= r_cycle + 64'd1;
    end
  end

endmodule

// File: tb/tb_axil_ctrl_slave.sv
// Directed bench for axil_ctrl_slave: a table of single transactions plus
// hand-written sequences for handshake timing, counters and reset abort.
module tb_axil_ctrl_slave;

  localparam logic [31:0] VERSION_VAL = 32'd20200610;
  localparam logic [31:0] STATUS_VAL  = 32'hDEAD_BEEF;
  localparam int          TMO         = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] ctrl_out;
  logic [31:0] status_in;
  logic        event_pulse;
  logic        pulse_on_accept;

  axil_ctrl_slave_if bus();

  axil_ctrl_slave #(
    .ADDR_BITS (8),
    .VERSION   (VERSION_VAL),
    .CTRL_RESET(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_axil     (bus),
    .ctrl_out   (ctrl_out),
    .status_in  (status_in),
    .event_pulse(event_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Full write: present AW+W, wait for ready, then collect B.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    @(negedge clk);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < TMO) begin @(negedge clk); n++; end
    if (!bus.awready) begin
      chk("awready_timeout", 32'(bus.awready), 32'd1);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      return;
    end
    event_pulse = pulse_on_accept;
    @(negedge clk);
    event_pulse = 1'b0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("bvalid_after_accept", 32'(bus.bvalid), 32'd1);
    n = 0;
    while (!bus.bvalid && n < TMO) begin @(negedge clk); n++; end
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  // Full read: present AR, wait for ready, expect R on the following cycle.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    data = 'x; resp = 2'bxx;
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < TMO) begin @(negedge clk); n++; end
    if (!bus.arready) begin
      chk("arready_timeout", 32'(bus.arready), 32'd1);
      bus.arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("rvalid_latency", 32'(bus.rvalid), 32'd1);
    data = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [31:0] exp_ctrl;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [31:0] exp_rdata,
                              input logic [1:0] exp_resp, input logic [31:0] exp_ctrl);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.exp_rdata = exp_rdata; v.exp_resp = exp_resp; v.exp_ctrl = exp_ctrl;
    return v;
  endfunction

  localparam int NV = 22;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, rd2, wr_resp32;
    logic [1:0]  resp, resp2;
    logic        ok;
    int          n;

    vecs[0]  = mk(0, 32'h18,  0,            4'h0, 32'h0,        2'b00, 32'h0);
    vecs[1]  = mk(0, 32'h00,  0,            4'h0, VERSION_VAL,  2'b00, 32'h0);
    vecs[2]  = mk(0, 32'h04,  0,            4'h0, 32'h0,        2'b00, 32'h0);
    vecs[3]  = mk(1, 32'h08,  32'hAABBCCDD, 4'hF, 32'h0,        2'b00, 32'h0);
    vecs[4]  = mk(1, 32'h08,  32'h00001100, 4'h2, 32'h0,        2'b00, 32'h0);
    vecs[5]  = mk(0, 32'h08,  0,            4'h0, 32'hAABB11DD, 2'b00, 32'h0);
    vecs[6]  = mk(1, 32'h08,  32'hFFFFFFFF, 4'h0, 32'h0,        2'b00, 32'h0);
    vecs[7]  = mk(0, 32'h08,  0,            4'h0, 32'hAABB11DD, 2'b00, 32'h0);
    vecs[8]  = mk(1, 32'h04,  32'h12345678, 4'hF, 32'h0,        2'b00, 32'h12345678);
    vecs[9]  = mk(1, 32'h04,  32'h000000A5, 4'h1, 32'h0,        2'b00, 32'h123456A5);
    vecs[10] = mk(0, 32'h04,  0,            4'h0, 32'h123456A5, 2'b00, 32'h123456A5);
    vecs[11] = mk(1, 32'h00,  32'hFFFFFFFF, 4'hF, 32'h0,        2'b00, 32'h123456A5);
    vecs[12] = mk(0, 32'h00,  0,            4'h0, VERSION_VAL,  2'b00, 32'h123456A5);
    vecs[13] = mk(1, 32'h40,  32'hFFFFFFFF, 4'hF, 32'h0,        2'b10, 32'h123456A5);
    vecs[14] = mk(0, 32'h40,  0,            4'h0, 32'h0,        2'b10, 32'h123456A5);
    vecs[15] = mk(0, 32'h0C,  0,            4'h0, STATUS_VAL,   2'b00, 32'h123456A5);
    vecs[16] = mk(1, 32'h0C,  32'h0,        4'hF, 32'h0,        2'b00, 32'h123456A5);
    vecs[17] = mk(0, 32'h1C,  0,            4'h0, 32'h0,        2'b10, 32'h123456A5);
    vecs[18] = mk(0, 32'h106, 0,            4'h0, 32'h123456A5, 2'b00, 32'h123456A5);
    vecs[19] = mk(1, 32'h14,  32'h0,        4'hF, 32'h0,        2'b00, 32'h123456A5);
    vecs[20] = mk(1, 32'h18,  32'h0,        4'hF, 32'h0,        2'b00, 32'h123456A5);
    vecs[21] = mk(0, 32'h10,  0,            4'h0, 32'h0,        2'b00, 32'h123456A5);

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    status_in = STATUS_VAL; event_pulse = 1'b0; pulse_on_accept = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
    chk("rst_valid", 32'({bus.bvalid, bus.rvalid}), 32'd0);
    chk("rst_resp",  32'({bus.bresp, bus.rresp}), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_ctrl",  ctrl_out, 32'd0);
    rstn = 1'b1;

    // Table of single transactions
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end
      chk($sformatf("vec%0d_ctrl_out", i), ctrl_out, vecs[i].exp_ctrl);
    end

    // AW presented alone for 5 cycles must not be accepted
    @(negedge clk);
    bus.awaddr = 32'h08; bus.wdata = 32'h5555_0000; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b0;
    ok = 1'b1;
    repeat (5) begin @(negedge clk); if (bus.awready || bus.wready) ok = 1'b0; end
    chk("aw_alone_not_accepted", 32'(ok), 32'd1);
    bus.wvalid = 1'b1;
    @(negedge clk);
    chk("awready_with_w", 32'(bus.awready), 32'd1);
    chk("wready_with_aw", 32'(bus.wready), 32'd1);
    @(negedge clk);
    // Second write waits behind an unacknowledged response
    bus.wdata = 32'h0000_7777; bus.wstrb = 4'h3;
    ok = 1'b1;
    repeat (10) begin
      if (!bus.bvalid || bus.bresp != 2'b00 || bus.awready || bus.wready) ok = 1'b0;
      @(negedge clk);
    end
    chk("bvalid_held_no_accept", 32'(ok), 32'd1);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    chk("bvalid_dropped", 32'(bus.bvalid), 32'd0);
    n = 0;
    while (!bus.awready && n < TMO) begin @(negedge clk); n++; end
    chk("second_write_accepted", 32'(bus.awready), 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < TMO) begin @(negedge clk); n++; end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    axi_read(32'h08, rd, resp);
    chk("scratch_after_pair", rd, 32'h5555_7777);

    // Event counter: three pulses, clear coincident with a pulse, wrap
    @(negedge clk);
    event_pulse = 1'b1;
    repeat (3) @(negedge clk);
    event_pulse = 1'b0;
    axi_read(32'h10, rd, resp);
    chk("evt_cnt_3", rd, 32'd3);
    pulse_on_accept = 1'b1;
    axi_write(32'h10, 32'h0, 4'h0, resp);
    pulse_on_accept = 1'b0;
    chk("evt_clr_bresp", 32'(resp), 32'd0);
    axi_read(32'h10, rd, resp);
    chk("evt_clr_with_pulse", rd, 32'd1);
    force dut.r_evt_cnt = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.r_evt_cnt;
    event_pulse = 1'b1;
    @(negedge clk);
    event_pulse = 1'b0;
    axi_read(32'h10, rd, resp);
    chk("evt_wrap", rd, 32'd0);

    // CYCLE_HI returns the half latched by the CYCLE_LO read
    force dut.r_cycle = 64'h0000_0001_FFFF_FFFE;
    axi_read(32'h14, rd, resp);
    chk("cycle_lo", rd, 32'hFFFF_FFFE);
    force dut.r_cycle = 64'h0000_0002_0000_0001;
    axi_read(32'h18, rd, resp);
    chk("cycle_hi_shadow", rd, 32'h0000_0001);
    release dut.r_cycle;
    // Back-to-back LO reads accept four cycles apart
    axi_read(32'h14, rd, resp);
    axi_read(32'h14, rd2, resp);
    chk("cycle_free_running", rd2 - rd, 32'd4);

    // Same-register read and write accepted together: read sees old value
    fork
      axi_write(32'h04, 32'hCAFE_F00D, 4'hF, resp2);
      axi_read(32'h04, rd, resp);
    join
    chk("collision_read_old", rd, 32'h123456A5);
    chk("collision_ctrl_new", ctrl_out, 32'hCAFE_F00D);
    wr_resp32 = 32'(resp2);
    chk("collision_bresp", wr_resp32, 32'd0);

    // Reset during an accepted-but-unanswered write
    @(negedge clk);
    bus.awaddr = 32'h08; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < TMO) begin @(negedge clk); n++; end
    rstn = 1'b0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    chk("rst_abort_awready", 32'(bus.awready), 32'd0);
    chk("rst_abort_ctrl", ctrl_out, 32'd0);
    rstn = 1'b1;
    ok = 1'b1;
    repeat (5) begin @(negedge clk); if (bus.bvalid || bus.awready) ok = 1'b0; end
    chk("rst_abort_no_bresp", 32'(ok), 32'd1);

    // Reset while read data is pending
    @(negedge clk);
    bus.araddr = 32'h00; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.rvalid && n < TMO) begin @(negedge clk); n++; end
    bus.arvalid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_abort_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_abort_rdata", bus.rdata, 32'd0);
    rstn = 1'b1;
    ok = 1'b1;
    repeat (5) begin @(negedge clk); if (bus.rvalid || bus.arready) ok = 1'b0; end
    chk("rst_abort_no_rresp", 32'(ok), 32'd1);
    axi_read(32'h08, rd, resp);
    chk("rst_scratch_cleared", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
